wb_burst_master: RTL and testbench

Synthesisable, parametrised Wishbone B4 registered-feedback master. It turns a command plus write-data stream into classic or incrementing-burst bus cycles, and returns read data as a stream. It sits between test traffic generators or DMA logic and the SDRAM controller's Wishbone slave port, replacing the behavioural read/write tasks in synthesisable designs.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_stall_timer.sv | 29 ++
 rtl/wb_burst_master.sv | 162 ++++++++++++++++
 tb/tb_wb_burst_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and state type for the Wishbone burst master.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

endpackage

// File: rtl/wb_stall_timer.sv
// Counts consecutive stalled bus cycles; expired fires on the last allowed stall cycle.
module wb_stall_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (stall) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Abort in the stall cycle that would make the count reach the limit.
    assign expired = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 registered-feedback burst master (classic / linear incrementing bursts).
// Optional stall abort enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 26,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic                    wr_valid_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    wr_ready_o,
    output logic                    rd_valid_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_last_o,
    output logic                    resp_valid_o,
    output logic                    resp_err_o,
    output logic                    resp_timeout_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output wbm_state_t              dbg_state_o
);

    localparam int SW = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_burst_master: bad DATA_WIDTH or TIMEOUT_CYCLES");
    end

    wbm_state_t            state_q, state_d;
    logic                  we_q, we_d, burst_q, burst_d;
    logic                  err_q, err_d, to_q, to_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic                  in_bus, stb, beat_ack, beat_err, last_beat, timeout_hit;

    // Handshakes: cmd and wr transfer in any cycle where valid and ready are both high;
    // rd_valid_o has no ready and must be taken in the cycle it is asserted.
    assign in_bus    = (state_q == BUS);
    assign stb       = in_bus && (!we_q || wr_valid_i);
    assign beat_err  = stb && wb_err_i;
    assign beat_ack  = stb && wb_ack_i && !wb_err_i;
    assign last_beat = (beats_q == '0);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    wb_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clear  (!in_bus || beat_ack),
        .stall  (in_bus && !beat_ack && !beat_err),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        burst_d = burst_q;
        err_d   = err_q;
        to_d    = to_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = BUS;
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    sel_d   = cmd_sel_i;
                    beats_d = cmd_len_i;
                    burst_d = (cmd_len_i != '0);
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            BUS: begin
                if (beat_err || timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    to_d    = timeout_hit && !beat_err;
                end else if (beat_ack) begin
                    addr_d = addr_q + ADDR_WIDTH'(SW);
                    if (last_beat) begin
                        state_d = RESP;
                    end else begin
                        beats_d = beats_q - LEN_WIDTH'(1);
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset keeps cmd_ready_o low while reset is held.
    assign cmd_ready_o    = wb_rst_n_i && (state_q == IDLE);
    assign wr_ready_o     = we_q && beat_ack;
    assign rd_valid_o     = !we_q && beat_ack;
    assign rd_data_o      = rd_valid_o ? wb_dat_i : '0;
    assign rd_last_o      = rd_valid_o && last_beat;
    assign resp_valid_o   = (state_q == RESP);
    assign resp_err_o     = resp_valid_o && err_q;
    assign resp_timeout_o = resp_valid_o && to_q;

    assign wb_cyc_o    = in_bus;
    assign wb_stb_o    = stb;
    assign wb_we_o     = in_bus && we_q;
    assign wb_addr_o   = in_bus ? addr_q : '0;
    assign wb_sel_o    = in_bus ? sel_q : '0;
    assign wb_dat_o    = (in_bus && we_q) ? wr_data_i : '0;
    assign wb_cti_o    = (!in_bus || !burst_q) ? CTI_CLASSIC :
                         (last_beat ? CTI_EOB : CTI_INCR);
    assign wb_bte_o    = BTE_LINEAR;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master.
module tb_wb_burst_master;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int LW = 8;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          wb_clk_i, wb_rst_n_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic [SW-1:0] cmd_sel_i;
    logic          wr_valid_i, wr_ready_o;
    logic [DW-1:0] wr_data_i;
    logic          rd_valid_o, rd_last_o;
    logic [DW-1:0] rd_data_o;
    logic          resp_valid_o, resp_err_o, resp_timeout_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [SW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i, wb_err_i;
    wbm_state_t    dbg_state_o;

    int checks = 0;
    int errors = 0;

    wb_burst_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_timeout_o(resp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks; all stimulus changes happen on the falling edge
    task automatic step();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_sel_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [SW-1:0] sel);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len; cmd_sel_i = sel;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL cmd_ready: got %b want 1", cmd_ready_o); end
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_n_i = 1'b0;
        idle_inputs();
        cmd_valid_i = 1'b1;
        step(); step();
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready_o); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o} !== 6'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o}); end
        checks++; if ({wb_addr_o, wb_sel_o} !== '0) begin errors++; $display("FAIL rst_addr_sel: got %h want 0", {wb_addr_o, wb_sel_o}); end
        checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state_o); end
        cmd_valid_i = 1'b0;
        step();
        wb_rst_n_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready_o); end
        checks++; if (wb_bte_o !== 2'b00) begin errors++; $display("FAIL bte: got %b want 00", wb_bte_o); end
        step();
    endtask

    task automatic test_single_write();
        int wr_cnt = 0;
        issue(1'b1, 26'h100, 8'd0, 4'hF);
        wr_valid_i = 1'b1; wr_data_i = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            wb_ack_i = (k == 2);
            #1;
            if (k == 0) begin
                checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin errors++; $display("FAIL sw_ctrl: got %b want 111", {wb_cyc_o, wb_stb_o, wb_we_o}); end
                checks++; if (wb_cti_o !== 3'b000) begin errors++; $display("FAIL sw_cti: got %b want 000", wb_cti_o); end
                checks++; if (wb_sel_o !== 4'hF) begin errors++; $display("FAIL sw_sel: got %h want f", wb_sel_o); end
                checks++; if (wb_addr_o !== 26'h100) begin errors++; $display("FAIL sw_addr: got %h want 100", wb_addr_o); end
                checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dat: got %h want deadbeef", wb_dat_o); end
            end
            if (wr_ready_o === 1'b1) wr_cnt++;
            step();
        end
        wb_ack_i = 1'b0; wr_valid_i = 1'b0;
        #1;
        checks++; if (wr_cnt != 1) begin errors++; $display("FAIL sw_wr_ready_count: got %0d want 1", wr_cnt); end
        checks++; if ({resp_valid_o, resp_err_o, resp_timeout_o, wb_cyc_o} !== 4'b1000) begin errors++; $display("FAIL sw_resp: got %b want 1000", {resp_valid_o, resp_err_o, resp_timeout_o, wb_cyc_o}); end
        step();
        #1;
        checks++; if ({cmd_ready_o, resp_valid_o} !== 2'b10) begin errors++; $display("FAIL sw_back_idle: got %b want 10", {cmd_ready_o, resp_valid_o}); end
        step();
    endtask

    task automatic test_read_burst();
        logic [AW-1:0] exp_addr [4];
        logic [2:0]    exp_cti  [4];
        int n = 0, rdv = 0;
        logic seen_resp = 1'b0;
        exp_addr[0] = 26'h3FFFFF8; exp_addr[1] = 26'h3FFFFFC; exp_addr[2] = 26'h0000000; exp_addr[3] = 26'h0000004;
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010; exp_cti[2] = 3'b010; exp_cti[3] = 3'b111;
        issue(1'b0, 26'h3FFFFF8, 8'd3, 4'hF);
        for (int c = 0; c < 20 && !seen_resp; c++) begin
            #1;
            wb_ack_i = wb_stb_o;
            wb_dat_i = 32'hC0DE0000 + n;
            #1;
            if (rd_valid_o === 1'b1) rdv++;
            if (resp_valid_o === 1'b1) begin
                seen_resp = 1'b1;
                checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL rb_resp_err: got %b want 0", resp_err_o); end
            end else if (wb_stb_o === 1'b1 && n < 4) begin
                checks++; if (wb_addr_o !== exp_addr[n]) begin errors++; $display("FAIL rb_addr%0d: got %h want %h", n, wb_addr_o, exp_addr[n]); end
                checks++; if (wb_cti_o !== exp_cti[n]) begin errors++; $display("FAIL rb_cti%0d: got %b want %b", n, wb_cti_o, exp_cti[n]); end
                checks++; if (rd_data_o !== 32'hC0DE0000 + n) begin errors++; $display("FAIL rb_data%0d: got %h want %h", n, rd_data_o, 32'hC0DE0000 + n); end
                checks++; if (rd_last_o !== (n == 3)) begin errors++; $display("FAIL rb_last%0d: got %b want %b", n, rd_last_o, (n == 3)); end
                n++;
            end
            step();
            wb_ack_i = 1'b0;
        end
        checks++; if (rdv != 4) begin errors++; $display("FAIL rb_rd_valid_count: got %0d want 4", rdv); end
        checks++; if (seen_resp !== 1'b1) begin errors++; $display("FAIL rb_resp_seen: got %b want 1", seen_resp); end
    endtask

    task automatic test_write_burst();
        int widx = 0, gap = 3, gap_seen = 0, acks = 0;
        logic in_gap;
        logic seen_resp = 1'b0;
        issue(1'b1, 26'h200, 8'd7, 4'hF);
        for (int c = 0; c < 40 && !seen_resp; c++) begin
            in_gap = 1'b0;
            if (widx == 3 && gap > 0) begin
                wr_valid_i = 1'b0; gap--; in_gap = 1'b1;
            end else begin
                wr_valid_i = (widx < 8); wr_data_i = 32'h11110000 + widx;
            end
            #1;
            wb_ack_i = wb_stb_o;
            #1;
            if (resp_valid_o === 1'b1) begin
                seen_resp = 1'b1;
                checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL wb_resp_err: got %b want 0", resp_err_o); end
            end else begin
                if (in_gap) begin
                    gap_seen++;
                    checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin errors++; $display("FAIL wb_gap: got cyc/stb %b want 10", {wb_cyc_o, wb_stb_o}); end
                end
                if (wr_ready_o === 1'b1) begin
                    checks++; if (wb_dat_o !== 32'h11110000 + widx) begin errors++; $display("FAIL wb_data%0d: got %h want %h", widx, wb_dat_o, 32'h11110000 + widx); end
                    checks++; if (wb_addr_o !== 26'h200 + 4 * widx) begin errors++; $display("FAIL wb_addr%0d: got %h want %h", widx, wb_addr_o, 26'h200 + 4 * widx); end
                    checks++; if (wb_cti_o !== ((widx == 7) ? 3'b111 : 3'b010)) begin errors++; $display("FAIL wb_cti%0d: got %b", widx, wb_cti_o); end
                    widx++; acks++;
                end
            end
            step();
            wb_ack_i = 1'b0;
        end
        wr_valid_i = 1'b0;
        checks++; if (acks != 8) begin errors++; $display("FAIL wb_ack_count: got %0d want 8", acks); end
        checks++; if (gap_seen != 3) begin errors++; $display("FAIL wb_gap_count: got %0d want 3", gap_seen); end
        checks++; if (seen_resp !== 1'b1) begin errors++; $display("FAIL wb_resp_seen: got %b want 1", seen_resp); end
    endtask

    task automatic test_read_error();
        int rdv = 0;
        issue(1'b0, 26'h300, 8'd7, 4'hF);
        for (int n = 0; n < 3; n++) begin
            #1;
            wb_ack_i = 1'b1; wb_err_i = (n == 2); wb_dat_i = 32'hE0000000 + n;
            #1;
            if (rd_valid_o === 1'b1) rdv++;
            if (n == 2) begin
                checks++; if ({wb_cyc_o, wb_stb_o, rd_valid_o} !== 3'b110) begin errors++; $display("FAIL re_err_beat: got cyc/stb/rdv %b want 110", {wb_cyc_o, wb_stb_o, rd_valid_o}); end
            end
            step();
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        checks++; if (rdv != 2) begin errors++; $display("FAIL re_rd_valid_count: got %0d want 2", rdv); end
        checks++; if ({wb_cyc_o, resp_valid_o, resp_err_o, resp_timeout_o} !== 4'b0110) begin errors++; $display("FAIL re_resp: got cyc/v/err/to %b want 0110", {wb_cyc_o, resp_valid_o, resp_err_o, resp_timeout_o}); end
        step();
        #1;
        checks++; if ({resp_valid_o, resp_err_o} !== 2'b00) begin errors++; $display("FAIL re_err_cleared: got %b want 00", {resp_valid_o, resp_err_o}); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        issue(1'b0, 26'h400, 8'd7, 4'hF);
        wb_ack_i = 1'b1;
        step(); step();
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, rd_valid_o, resp_valid_o, cmd_ready_o, wr_ready_o} !== 10'b0) begin errors++; $display("FAIL mr_ctrl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, rd_valid_o, resp_valid_o, cmd_ready_o, wr_ready_o}); end
        checks++; if ({wb_addr_o, wb_dat_o, wb_sel_o, rd_data_o} !== '0) begin errors++; $display("FAIL mr_data: got %h want 0", {wb_addr_o, wb_dat_o, wb_sel_o, rd_data_o}); end
        checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL mr_state: got %0d want 0", dbg_state_o); end
        wb_ack_i = 1'b0;
        step();
        wb_rst_n_i = 1'b1;
        step();
        issue(1'b0, 26'h40, 8'd0, 4'h3);
        #1;
        wb_ack_i = wb_stb_o; wb_dat_i = 32'h5A5A5A5A;
        #1;
        checks++; if ({rd_valid_o, rd_last_o, wb_cti_o, wb_sel_o} !== {2'b11, 3'b000, 4'h3}) begin errors++; $display("FAIL mr_rd_ctrl: got %b", {rd_valid_o, rd_last_o, wb_cti_o, wb_sel_o}); end
        checks++; if (rd_data_o !== 32'h5A5A5A5A) begin errors++; $display("FAIL mr_rd_data: got %h want 5a5a5a5a", rd_data_o); end
        checks++; if (wb_addr_o !== 26'h40) begin errors++; $display("FAIL mr_rd_addr: got %h want 40", wb_addr_o); end
        step();
        wb_ack_i = 1'b0;
        #1;
        checks++; if ({resp_valid_o, resp_err_o} !== 2'b10) begin errors++; $display("FAIL mr_resp: got %b want 10", {resp_valid_o, resp_err_o}); end
        step();
    endtask

    task automatic test_timeout();
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        int cyc_cnt = 0;
        logic seen_resp = 1'b0;
        issue(1'b0, 26'h500, 8'd0, 4'hF);
        for (int c = 0; c < 40 && !seen_resp; c++) begin
            #1;
            if (wb_cyc_o === 1'b1) cyc_cnt++;
            if (resp_valid_o === 1'b1) begin
                seen_resp = 1'b1;
                checks++; if ({resp_err_o, resp_timeout_o} !== 2'b11) begin errors++; $display("FAIL to_resp: got err/to %b want 11", {resp_err_o, resp_timeout_o}); end
            end
            step();
        end
        checks++; if (cyc_cnt != TO) begin errors++; $display("FAIL to_stall_cycles: got %0d want %0d", cyc_cnt, TO); end
        checks++; if (seen_resp !== 1'b1) begin errors++; $display("FAIL to_resp_seen: got %b want 1", seen_resp); end
`else
        issue(1'b0, 26'h500, 8'd0, 4'hF);
        repeat (1000) step();
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, resp_valid_o, resp_timeout_o} !== 4'b1100) begin errors++; $display("FAIL to_wait_forever: got cyc/stb/v/to %b want 1100", {wb_cyc_o, wb_stb_o, resp_valid_o, resp_timeout_o}); end
        step();
        wb_rst_n_i = 1'b0;
        step();
        wb_rst_n_i = 1'b1;
        step();
`endif
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_write_burst();
        test_read_error();
        test_reset_mid_burst();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
